// File: rtl/text_pkg.sv
// Shared definitions for the text tile cursor controller: op codes, screen size
// defaults, FSM state encoding and the {y,x} tile RAM address packing.
package text_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_UP    = 3'd2;
  localparam logic [2:0] OP_DOWN  = 3'd3;
  localparam logic [2:0] OP_LEFT  = 3'd4;
  localparam logic [2:0] OP_RIGHT = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;
  localparam logic [2:0] OP_HOME  = 3'd7;

  localparam int MAX_X_DEF = 80;
  localparam int MAX_Y_DEF = 30;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  function automatic logic [11:0] pack_addr(input logic [4:0] y, input logic [6:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/cursor_wrap_counter.sv
// X/Y modulo position counter with increment/decrement/clear controls and an
// optional carry from an x wrap into y (raster advance).
module cursor_wrap_counter
  import text_pkg::*;
#(
  parameter int MAX_X = MAX_X_DEF,
  parameter int MAX_Y = MAX_Y_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       x_inc_i,
  input  logic       x_dec_i,
  input  logic       y_inc_i,
  input  logic       y_dec_i,
  input  logic       carry_i,
  output logic [6:0] x_o,
  output logic [4:0] y_o
);

  localparam logic [6:0] X_LAST = 7'(MAX_X - 1);
  localparam logic [4:0] Y_LAST = 5'(MAX_Y - 1);

  logic [6:0] x_q, x_d;
  logic [4:0] y_q, y_d;
  logic       x_wrap;

  // Wrap by explicit compare so non-power-of-two sizes never reach unused codes.
  function automatic logic [4:0] y_next(input logic [4:0] y);
    return (y == Y_LAST) ? 5'd0 : y + 5'd1;
  endfunction

  function automatic logic [4:0] y_prev(input logic [4:0] y);
    return (y == 5'd0) ? Y_LAST : y - 5'd1;
  endfunction

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    x_wrap = 1'b0;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else begin
      if (x_inc_i) begin
        if (x_q == X_LAST) begin
          x_d    = '0;
          x_wrap = 1'b1;
        end else begin
          x_d = x_q + 7'd1;
        end
      end else if (x_dec_i) begin
        x_d = (x_q == 7'd0) ? X_LAST : x_q - 7'd1;
      end
      if (y_inc_i || (carry_i && x_wrap)) begin
        y_d = y_next(y_q);
      end else if (y_dec_i) begin
        y_d = y_prev(y_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;

endmodule

// File: rtl/text_cursor_ctrl.sv
// Command sequencer for the 80x30 text tile RAM: cursor moves, character writes
// and a blocking clear sweep. Cursor blinking is built only with CURSOR_BLINK_EN.
module text_cursor_ctrl
  import text_pkg::*;
#(
  parameter int         MAX_X      = MAX_X_DEF,
  parameter int         MAX_Y      = MAX_Y_DEF,
  parameter logic [6:0] BLANK_CHAR = 7'h00,
  parameter int         BLINK_DIV  = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [6:0]  cmd_char,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [6:0]  wr_data,
  output logic [6:0]  cur_x,
  output logic [4:0]  cur_y,
  output logic        busy,
  output logic        cursor_on
);

  state_t      state_q;
  logic        wr_en_q;
  logic [11:0] wr_addr_q;
  logic [6:0]  wr_data_q;
  logic        busy_q;
  logic        accept;
  logic [6:0]  sx;
  logic [4:0]  sy;
  logic        sweep_last;

  assign cmd_ready  = (state_q == ST_IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign sweep_last = (sx == 7'(MAX_X - 1)) && (sy == 5'(MAX_Y - 1));

  cursor_wrap_counter #(.MAX_X(MAX_X), .MAX_Y(MAX_Y)) u_cursor (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (accept && ((cmd_op == OP_HOME) || (cmd_op == OP_CLEAR))),
    .x_inc_i (accept && ((cmd_op == OP_WRITE) || (cmd_op == OP_RIGHT))),
    .x_dec_i (accept && (cmd_op == OP_LEFT)),
    .y_inc_i (accept && (cmd_op == OP_DOWN)),
    .y_dec_i (accept && (cmd_op == OP_UP)),
    .carry_i (cmd_op == OP_WRITE),
    .x_o     (cur_x),
    .y_o     (cur_y)
  );

  // Sweep position is reset on CLEAR entry and walks the screen in raster order.
  cursor_wrap_counter #(.MAX_X(MAX_X), .MAX_Y(MAX_Y)) u_sweep (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (accept && (cmd_op == OP_CLEAR)),
    .x_inc_i (state_q == ST_CLEAR),
    .x_dec_i (1'b0),
    .y_inc_i (1'b0),
    .y_dec_i (1'b0),
    .carry_i (1'b1),
    .x_o     (sx),
    .y_o     (sy)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_WRITE: begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= pack_addr(cur_y, cur_x);
                wr_data_q <= cmd_char;
              end
              OP_CLEAR: begin
                state_q <= ST_CLEAR;
                busy_q  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_CLEAR: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= pack_addr(sy, sx);
          wr_data_q <= BLANK_CHAR;
          if (sweep_last) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

`ifdef CURSOR_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt_q;
  logic          cursor_on_q;
  logic          blink_hold;

  // Typing, moving or clearing keeps the cursor solid and restarts the period.
  assign blink_hold = (state_q == ST_CLEAR) ||
                      (accept && (cmd_op != OP_NOP));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
      cursor_on_q <= 1'b1;
    end else if (blink_hold) begin
      blink_cnt_q <= '0;
      cursor_on_q <= 1'b1;
    end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      cursor_on_q <= ~cursor_on_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  assign cursor_on = cursor_on_q;
`else
  // BLINK_DIV only matters when blinking is built in; the cursor is always shown.
  assign cursor_on = 1'b1 | (BLINK_DIV == 0);
`endif

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Directed scoreboard bench for text_cursor_ctrl: expected RAM writes are queued
// when commands are driven and popped by a negedge monitor.
module tb_text_cursor_ctrl;

  localparam logic [2:0] C_NOP = 3'd0, C_WRITE = 3'd1, C_UP = 3'd2, C_DOWN = 3'd3;
  localparam logic [2:0] C_LEFT = 3'd4, C_RIGHT = 3'd5, C_CLEAR = 3'd6, C_HOME = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = 3'd0;
  logic [6:0]  cmd_char = 7'd0;
  logic        cmd_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [6:0]  wr_data;
  logic [6:0]  cur_x;
  logic [4:0]  cur_y;
  logic        busy;
  logic        cursor_on;

  text_cursor_ctrl #(
    .MAX_X(80), .MAX_Y(30), .BLANK_CHAR(7'h00), .BLINK_DIV(4)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_char(cmd_char), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cur_x(cur_x), .cur_y(cur_y), .busy(busy),
    .cursor_on(cursor_on)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_fail = 0;
  int          n_checks = 0;
  logic [18:0] exp_q[$];
  int          ex = 0;
  int          ey = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic chk_cursor(input string tag);
    chk({tag, "_x"}, 32'(cur_x), 32'(ex));
    chk({tag, "_y"}, 32'(cur_y), 32'(ey));
  endtask

  // Drive one command for one edge (block is ready) and update the cursor model.
  task automatic send(input logic [2:0] op, input logic [6:0] ch);
    logic [11:0] a;
    if (op == C_WRITE) begin
      a = 12'(ey * 128 + ex);
      exp_q.push_back({a, ch});
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_char  = ch;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = C_NOP;
    case (op)
      C_WRITE: begin
        ex++;
        if (ex == 80) begin
          ex = 0;
          ey = (ey == 29) ? 0 : ey + 1;
        end
      end
      C_UP:    ey = (ey == 0) ? 29 : ey - 1;
      C_DOWN:  ey = (ey == 29) ? 0 : ey + 1;
      C_LEFT:  ex = (ex == 0) ? 79 : ex - 1;
      C_RIGHT: ex = (ex == 79) ? 0 : ex + 1;
      C_CLEAR, C_HOME: begin
        ex = 0;
        ey = 0;
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    logic [18:0] e;
    if (reset === 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("wr_en_spurious", 32'(wr_en), 32'd0);
      end else if (wr_en === 1'b1) begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e[18:7]));
        chk("wr_data", 32'(wr_data), 32'(e[6:0]));
      end
    end
  end

  initial begin
    int busy_cycles;
    int ready_bad;
    logic [2:0] op;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_cursor_on", 32'(cursor_on), 32'd1);
    chk_cursor("rst");
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    send(C_WRITE, 7'h41);
    chk_cursor("write_a");

    send(C_HOME, 7'd0);
    send(C_LEFT, 7'd0);
    chk_cursor("to_79_0");
    send(C_WRITE, 7'h42);
    chk_cursor("write_eol");

    send(C_HOME, 7'd0);
    send(C_UP, 7'd0);
    send(C_LEFT, 7'd0);
    chk_cursor("to_79_29");
    send(C_WRITE, 7'h7A);
    chk_cursor("write_last");

    send(C_LEFT, 7'd0);
    chk_cursor("left_wrap");
    send(C_UP, 7'd0);
    chk_cursor("up_wrap");
    send(C_RIGHT, 7'd0);
    chk_cursor("right_wrap");
    send(C_DOWN, 7'd0);
    chk_cursor("down_wrap");
    send(C_NOP, 7'h55);
    chk_cursor("nop");

    for (int k = 0; k < 8; k++) begin
      op = 3'($urandom_range(1, 7));
      if (op == C_CLEAR) op = C_WRITE;
      send(op, 7'($urandom_range(0, 127)));
      chk_cursor("mixed");
    end

    send(C_HOME, 7'd0);
    repeat (5) send(C_RIGHT, 7'd0);
    repeat (5) send(C_DOWN, 7'd0);
    chk_cursor("at_5_5");
    for (int yy = 0; yy < 30; yy++)
      for (int xx = 0; xx < 80; xx++)
        exp_q.push_back({yy[4:0], xx[6:0], 7'h00});
    send(C_CLEAR, 7'd0);
    chk_cursor("clear_entry");
    chk("clear_busy", 32'(busy), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = C_WRITE;
    cmd_char  = 7'h51;
    exp_q.push_back({12'h000, 7'h51});
    busy_cycles = 0;
    ready_bad   = 0;
    while (busy === 1'b1 && busy_cycles < 3000) begin
      busy_cycles++;
      if (cmd_ready !== 1'b0) ready_bad++;
      @(posedge clk);
      #1;
    end
    chk("clear_busy_cycles", 32'(busy_cycles), 32'd2400);
    chk("clear_ready_low", 32'(ready_bad), 32'd0);
    chk("clear_done_ready", 32'(cmd_ready), 32'd1);
    chk_cursor("held_write_waits");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = C_NOP;
    ex = 1;
    chk_cursor("held_write_done");

    for (int i = 0; i < 100; i++)
      exp_q.push_back({5'(i / 80), 7'(i % 80), 7'h00});
    send(C_RIGHT, 7'd0);
    send(C_CLEAR, 7'd0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    ex = 0;
    ey = 0;
    chk("abort_wr_en", 32'(wr_en), 32'd0);
    chk("abort_wr_addr", 32'(wr_addr), 32'd0);
    chk("abort_wr_data", 32'(wr_data), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_cursor_on", 32'(cursor_on), 32'd1);
    chk_cursor("abort");
    chk("abort_queue", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    send(C_WRITE, 7'h43);
    chk_cursor("post_rst_write");

`ifdef CURSOR_BLINK_EN
    send(C_RIGHT, 7'd0);
    chk("blink_kick", 32'(cursor_on), 32'd1);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      #1;
      if (i == 3 || i == 4 || i == 8 || i == 9)
        chk("blink_phase", 32'(cursor_on), 32'((((i / 4) & 1) == 0) ? 1 : 0));
    end
    send(C_RIGHT, 7'd0);
    chk("blink_restart", 32'(cursor_on), 32'd1);
`else
    repeat (9) @(posedge clk);
    #1;
    chk("cursor_solid", 32'(cursor_on), 32'd1);
`endif

    @(negedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
